// File: rtl/uart_cmd_report.sv
// UART command/report engine: turns received ASCII bytes into button pulses and switch
// overrides, and on "?" sends a snapshot of the current time as an ASCII frame.
module uart_cmd_report #(
  parameter int                   NUM_BTN      = 4,
  parameter logic [NUM_BTN*8-1:0] BTN_CHARS    = {"D", "R", "L", "U"},
  parameter int                   NUM_SW       = 2,
  parameter logic [NUM_SW*8-1:0]  SW_CHARS     = {"W", "T"},
  parameter int                   PULSE_CYCLES = 1,
  parameter int                   DIGITS       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic [NUM_SW-1:0]     sw_phy,
  input  logic [4*DIGITS-1:0]   time_bcd,
  input  logic                  tx_done,
  output logic [NUM_BTN-1:0]    btn_uart,
  output logic [NUM_SW-1:0]     sw_final,
  output logic                  sw_override,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  tx_busy
);

  localparam int          CNT_W     = $clog2(PULSE_CYCLES + 1);
  localparam int          FRAME_LEN = DIGITS + DIGITS / 2 + 1;
  localparam logic [3:0]  LAST_IDX  = 4'(FRAME_LEN - 1);
  localparam logic [7:0]  CHAR_REPORT = 8'h3F;
  localparam logic [7:0]  CHAR_CLEAR  = 8'h50;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  logic [7:0] rx_char;

  always_comb begin
    rx_char = rx_data;
    if (rx_data >= 8'h61 && rx_data <= 8'h7A) rx_char = rx_data - 8'h20;
  end

  // Each button channel has its own down-counter so re-triggers simply reload it.
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] btn_q, btn_d;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (rx_done && rx_char == BTN_CHARS[i*8 +: 8]) cnt_d[i] = CNT_W'(PULSE_CYCLES);
      else if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
      btn_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      btn_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
      btn_q <= btn_d;
    end
  end

  logic [NUM_SW-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_SW-1:0] sw_ovr_q, sw_ovr_d;
  logic [NUM_SW-1:0] sw_final_q, sw_final_d;
  logic              ovr_on_q, ovr_on_d;

  // A physical switch movement always beats a UART command arriving in the same cycle.
  always_comb begin
    sw_ovr_d = sw_ovr_q;
    ovr_on_d = ovr_on_q;
    if (sync2_q != prev_q) begin
      ovr_on_d = 1'b0;
    end else if (rx_done) begin
      if (rx_char == CHAR_CLEAR) ovr_on_d = 1'b0;
      for (int j = 0; j < NUM_SW; j++) begin
        if (rx_char == SW_CHARS[j*8 +: 8]) begin
          sw_ovr_d = (ovr_on_q ? sw_ovr_q : sync2_q) ^ (NUM_SW'(1) << j);
          ovr_on_d = 1'b1;
        end
      end
    end
    sw_final_d = ovr_on_d ? sw_ovr_d : sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      sw_ovr_q   <= '0;
      ovr_on_q   <= 1'b0;
      sw_final_q <= '0;
    end else begin
      sync1_q    <= sw_phy;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      sw_ovr_q   <= sw_ovr_d;
      ovr_on_q   <= ovr_on_d;
      sw_final_q <= sw_final_d;
    end
  end

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (rx_done && rx_char == CHAR_REPORT) begin
          state_d = SEND;
          idx_d   = '0;
          snap_d  = time_bcd;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            state_d = SEND;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame is laid out in groups of three: digit, digit, colon (last group has no colon).
  logic [3:0] grp, pos, dig, nib;
  logic [7:0] frame_byte;

  always_comb begin
    grp = idx_q / 4'd3;
    pos = idx_q % 4'd3;
    dig = (grp << 1) + pos;
    nib = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (dig == 4'(d)) nib = snap_q[4*(DIGITS-1-d) +: 4];
    end
    if (idx_q == LAST_IDX)             frame_byte = 8'h0A;
    else if (idx_q == LAST_IDX - 4'd1) frame_byte = 8'h0D;
    else if (pos == 4'd2)              frame_byte = 8'h3A;
    else if (nib > 4'd9)               frame_byte = 8'h3F;
    else                               frame_byte = 8'h30 + {4'h0, nib};
  end

  always_comb begin
    tx_start = (state_q == SEND);
    tx_busy  = (state_q != IDLE);
    tx_data  = tx_busy ? frame_byte : 8'h00;
  end

  assign btn_uart    = btn_q;
  assign sw_final    = sw_final_q;
  assign sw_override = ovr_on_q;

endmodule

// File: tb/tb_uart_cmd_report.sv
// Directed bench for uart_cmd_report: command decode table, switch override corners,
// pulse stretching and the time report frame including abort by reset.
module tb_uart_cmd_report;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [1:0]  sw_phy;
  logic [23:0] time_bcd;
  logic        tx_done;
  logic [3:0]  btn_uart, btn3;
  logic [1:0]  sw_final, sw_final3;
  logic        sw_override, sw_override3;
  logic [7:0]  tx_data, tx_data3;
  logic        tx_start, tx_start3, tx_busy, tx_busy3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_cmd_report dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .sw_phy(sw_phy),
    .time_bcd(time_bcd), .tx_done(tx_done), .btn_uart(btn_uart), .sw_final(sw_final),
    .sw_override(sw_override), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  uart_cmd_report #(.PULSE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .sw_phy(sw_phy),
    .time_bcd(time_bcd), .tx_done(tx_done), .btn_uart(btn3), .sw_final(sw_final3),
    .sw_override(sw_override3), .tx_data(tx_data3), .tx_start(tx_start3), .tx_busy(tx_busy3)
  );

  typedef struct {
    logic [7:0] rx;
    logic [3:0] btn;
    logic [1:0] sw;
    logic       ovr;
  } vec_t;

  vec_t       vecs [12];
  logic [7:0] expFrame [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ch);
    rx_data = ch;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic runFrame(input int abortAfter, input int injectAt, input logic [23:0] midTime);
    int starts = 0;
    int dones = 0;
    int countdown = 0;
    int cyc = 0;
    int lastDoneCyc = -1;
    int idleCyc = -1;
    logic [7:0] held = 8'h00;
    applyStimulus(8'h3F);
    checkOutput("busy_rise", 32'(tx_busy), 32'd1);
    while (cyc < 1000) begin
      tx_done = 1'b0;
      rx_done = (cyc == injectAt);
      rx_data = 8'h3F;
      if (cyc == injectAt) time_bcd = midTime;
      if (tx_start) begin
        if (starts < 10) checkOutput($sformatf("byte%0d", starts), 32'(tx_data), 32'(expFrame[starts]));
        held = tx_data;
        starts++;
        countdown = 20;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          checkOutput($sformatf("hold%0d", dones), 32'(tx_data), 32'(held));
          tx_done = 1'b1;
          dones++;
          lastDoneCyc = cyc;
        end
      end
      if (abortAfter > 0 && dones == abortAfter && tx_done) begin
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(tx_busy), 32'd0);
        checkOutput("abort_start", 32'(tx_start), 32'd0);
        checkOutput("abort_data", 32'(tx_data), 32'd0);
        tx_done = 1'b0;
        rx_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        return;
      end
      tick();
      cyc++;
      if (!tx_busy) begin
        idleCyc = cyc;
        break;
      end
    end
    tx_done = 1'b0;
    rx_done = 1'b0;
    checkOutput("start_count", 32'(starts), 32'd10);
    checkOutput("busy_fall", 32'(idleCyc), 32'(lastDoneCyc + 1));
  endtask

  initial begin
    vecs[0]  = '{"U", 4'b0001, 2'b01, 1'b0};
    vecs[1]  = '{"l", 4'b0010, 2'b01, 1'b0};
    vecs[2]  = '{"X", 4'b0000, 2'b01, 1'b0};
    vecs[3]  = '{"r", 4'b0100, 2'b01, 1'b0};
    vecs[4]  = '{"D", 4'b1000, 2'b01, 1'b0};
    vecs[5]  = '{"T", 4'b0000, 2'b00, 1'b1};
    vecs[6]  = '{"W", 4'b0000, 2'b10, 1'b1};
    vecs[7]  = '{"P", 4'b0000, 2'b01, 1'b0};
    vecs[8]  = '{"w", 4'b0000, 2'b11, 1'b1};
    vecs[9]  = '{"p", 4'b0000, 2'b01, 1'b0};
    vecs[10] = '{"T", 4'b0000, 2'b00, 1'b1};
    vecs[11] = '{"W", 4'b0000, 2'b10, 1'b1};

    rst = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    sw_phy = 2'b01;
    time_bcd = 24'h123459;
    tx_done = 1'b0;
    repeat (3) tick();
    checkOutput("rst_btn", 32'(btn_uart), 32'd0);
    checkOutput("rst_sw", 32'(sw_final), 32'd0);
    checkOutput("rst_ovr", 32'(sw_override), 32'd0);
    checkOutput("rst_start", 32'(tx_start), 32'd0);
    checkOutput("rst_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    checkOutput("sw_settle", 32'(sw_final), 32'b01);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rx);
      checkOutput($sformatf("vec%0d_btn", i), 32'(btn_uart), 32'(vecs[i].btn));
      checkOutput($sformatf("vec%0d_sw", i), 32'(sw_final), 32'(vecs[i].sw));
      checkOutput($sformatf("vec%0d_ovr", i), 32'(sw_override), 32'(vecs[i].ovr));
      tick();
      checkOutput($sformatf("vec%0d_btn_clr", i), 32'(btn_uart), 32'd0);
    end

    // Physical switch change clears the override after the synchroniser delay.
    sw_phy = 2'b11;
    tick();
    tick();
    checkOutput("phy_early_ovr", 32'(sw_override), 32'd1);
    checkOutput("phy_early_sw", 32'(sw_final), 32'b10);
    tick();
    checkOutput("phy_ovr", 32'(sw_override), 32'd0);
    checkOutput("phy_sw", 32'(sw_final), 32'b11);

    // Command in the same cycle as a physical change loses.
    applyStimulus("T");
    checkOutput("coin_pre_sw", 32'(sw_final), 32'b10);
    sw_phy = 2'b01;
    tick();
    tick();
    applyStimulus("W");
    checkOutput("coin_ovr", 32'(sw_override), 32'd0);
    checkOutput("coin_sw", 32'(sw_final), 32'b01);

    // Pulse stretching with retrigger on the PULSE_CYCLES=3 instance.
    repeat (5) tick();
    applyStimulus("R");
    checkOutput("p3_n1", 32'(btn3), 32'b0100);
    tick();
    checkOutput("p3_n2", 32'(btn3), 32'b0100);
    applyStimulus("R");
    checkOutput("p3_n3", 32'(btn3), 32'b0100);
    tick();
    checkOutput("p3_n4", 32'(btn3), 32'b0100);
    tick();
    checkOutput("p3_n5", 32'(btn3), 32'b0100);
    tick();
    checkOutput("p3_n6", 32'(btn3), 32'b0000);

    expFrame = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A};
    runFrame(0, -1, 24'h0);
    repeat (3) tick();

    // Mid-frame "?" and time change are ignored; reset aborts after the 4th byte.
    runFrame(4, 30, 24'h0A5817);
    checkOutput("abort_ovr", 32'(sw_override), 32'd0);

    expFrame = '{8'h30, 8'h3F, 8'h3A, 8'h35, 8'h38, 8'h3A, 8'h31, 8'h37, 8'h0D, 8'h0A};
    runFrame(0, -1, 24'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_cmd_report.md
Name: uart_cmd_report

Overview:
- Generalised UART command/report engine; sits between `uart_controller` and the watch/stopwatch core.
- Decodes received ASCII bytes into NUM_BTN button pulses and NUM_SW switch overrides, merged with the physical switches.
- On a report request, serialises the current time as an ASCII frame through the UART transmitter with a start/done handshake.

Parameters:
- NUM_BTN, 4, number of button-pulse channels.
- BTN_CHARS, {"D","R","L","U"}, NUM_BTN*8 packed ASCII codes; byte i selects btn_uart[i].
- NUM_SW, 2, number of overridable switches.
- SW_CHARS, {"W","T"}, NUM_SW*8 packed ASCII codes; byte i toggles sw bit i.
- PULSE_CYCLES, 1, btn_uart pulse width in clocks (>=1).
- DIGITS, 6, BCD digits in report (even, 2..8).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- rx_data  input  8  received byte; valid when rx_done=1.
- rx_done  input  1  one-cycle strobe per received byte.
- sw_phy  input  NUM_SW  raw physical switches.
- time_bcd  input  4*DIGITS  current time; most significant digit in the top nibble.
- tx_done  input  1  one-cycle strobe when the transmitter finishes a byte.
- btn_uart  output  NUM_BTN  button pulses.
- sw_final  output  NUM_SW  effective switch value.
- sw_override  output  1  1 while UART override is active.
- tx_data  output  8  byte to transmit; held stable from tx_start until tx_done.
- tx_start  output  1  one-cycle transmit request.
- tx_busy  output  1  report frame in progress.

Behaviour:
- Reset: all outputs 0, override off, sync flops 0, FSM in IDLE.
- Reset is asynchronous and takes effect mid-frame or mid-pulse; it is the only way to abort a frame.
- Char folding: bytes 8'h61–8'h7A are folded to uppercase before any compare.
- Bytes matching no command are ignored.
- Buttons:
  - rx_done at cycle n with a BTN_CHARS[i] match drives btn_uart[i]=1 for cycles n+1..n+PULSE_CYCLES (registered).
  - A re-trigger during the pulse restarts that channel's counter.
  - Channels are independent.
- Switches:
  - sw_phy passes through a 2-flop synchroniser to give sw_sync.
  - SW_CHARS[j] match: if override is off, load sw_ovr = sw_sync with bit j inverted and set override on. If override is on, invert sw_ovr[j].
  - "P" clears override.
  - Any change of sw_sync versus its previous registered value clears override; the physical switch wins. If this coincides with a command in the same cycle, the physical change wins.
  - sw_final = override ? sw_ovr : sw_sync, registered; it updates at cycle n+1.
- Report FSM, states IDLE, SEND, WAIT:
  - IDLE: rx_done with "?" at cycle n latches time_bcd into a snapshot and moves to SEND; tx_busy=1 from n+1.
  - SEND: for one cycle, asserts tx_start=1 with tx_data = the current frame byte, then moves to WAIT. The first tx_start occurs at cycle n+1.
  - WAIT: holds tx_data until tx_done. On tx_done at cycle m, the next tx_start is at m+1; after the last byte the FSM returns to IDLE and tx_busy=0 at m+1.
  - "?" received while tx_busy=1 is ignored. Button and switch commands are still decoded during a frame.
  - tx_done while in IDLE or SEND is ignored.
- Frame format:
  - Digits are sent MSD first, each as 8'h30+nibble; a nibble >9 is sent as 8'h3F.
  - ":" (8'h3A) is inserted after every digit pair except the last.
  - The frame ends with CR (8'h0D) and LF (8'h0A).
  - Length = DIGITS + DIGITS/2 - 1 + 2; 10 bytes for DIGITS=6.
  - The byte index counter is sized for the maximum length of 13.
- The snapshot stays constant for the whole frame even if time_bcd changes.

Test Plan:
- Reset, then rx "U" at cycle n (PULSE_CYCLES=1) -> btn_uart=4'b0001 in cycle n+1 only. "l" -> 4'b0010. "X" -> no pulse.
- PULSE_CYCLES=3: "R" at n and again at n+2 -> btn_uart[2] high for cycles n+1..n+5 without a gap.
- sw_phy=2'b01 settled, rx "T" -> sw_final=2'b00 and sw_override=1. Rx "W" -> 2'b10. Rx "P" -> 2'b01 and sw_override=0.
- Override active with sw_final=2'b10, then toggle sw_phy to 2'b11 -> after synchroniser latency sw_override=0 and sw_final=2'b11.
- time_bcd=24'h123459, rx "?", bench returns tx_done 20 cycles after each tx_start -> bytes 31 32 3A 33 34 3A 35 39 0D 0A. Exactly 10 tx_start pulses; tx_busy falls one cycle after the 10th tx_done.
- During a frame: second "?" ignored; time_bcd changed mid-frame is not reflected in the bytes. Assert rst after the 4th byte -> tx_busy=0 and tx_start=0 immediately. A fresh "?" then restarts the frame from byte 0.
